// File: rtl/fw_sector_streamer_if.sv
// SD sector-read and UART byte-stream signals between the FW streamer and its peers.
interface fw_sector_streamer_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output sd_lba, sd_rd, tx_data, tx_valid,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  sd_lba, sd_rd, tx_data, tx_valid,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/fw_sector_streamer.sv
// Reads the mounted FW image sector by sector and streams each as
// index(2) + data(512) + XOR checksum over UART, with ACK/NACK/timeout retry.
module fw_sector_streamer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  ACK_BYTE       = 8'h79,
  parameter logic [7:0]  NACK_BYTE      = 8'h1F
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  img_mounted,
  input  logic [63:0]           img_size,
  fw_sector_streamer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error,
  output logic [15:0]           progress
);
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned POS_W   = 10;
  localparam int unsigned SIZE_W  = 25;
  localparam int unsigned SECT_W  = 17;
  localparam logic [POS_W-1:0]   POS_HDR_LAST  = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_DATA_LAST = POS_W'(513);
  localparam logic [POS_W-1:0]   POS_SUM       = POS_W'(514);
  localparam logic [63:0]        MAX_SIZE      = 64'h0000_0000_01FF_FE00;
  localparam logic [RETRY_W-1:0] RETRY_MAX     = RETRY_W'(MAX_RETRY);
  localparam logic [23:0]        TIMER_LAST    = TIMEOUT_CYCLES - 24'd1;

  typedef enum logic [3:0] {
    IDLE, SD_REQ, SD_XFER, TX_HDR, TX_DATA, TX_SUM, WAIT_ACK, DONE, ERROR
  } state_t;

  state_t              state, state_d;
  logic                img_ok;
  logic [SIZE_W-1:0]   size_q;
  logic [SECT_W-1:0]   sectors;
  logic [15:0]         n;
  logic [RETRY_W-1:0]  retry;
  logic [23:0]         timer;
  logic [POS_W-1:0]    pos;
  logic [8:0]          ptr, ptr_d;
  logic [7:0]          csum, rd_data;
  logic [7:0]          mem [512];
  logic [31:0]         sd_lba_q;
  logic                sd_rd_q, tx_valid_q;
  logic [7:0]          tx_data_q;

  logic in_busy, fire, start_go, abort, rx_ack, rx_nack, last_sector, pad;
  logic frame_start, load_data, busy_d, done_d;
  logic [1:0] error_d;

  assign bus.sd_lba   = sd_lba_q;
  assign bus.sd_rd    = sd_rd_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  // Event decode shared by next-state and output logic
  assign in_busy     = state inside {SD_REQ, SD_XFER, TX_HDR, TX_DATA, TX_SUM, WAIT_ACK};
  assign fire        = tx_valid_q & bus.tx_ready;
  assign start_go    = start & (state inside {IDLE, DONE, ERROR});
  assign abort       = img_mounted & in_busy;
  assign rx_ack      = (state == WAIT_ACK) & ~img_mounted & bus.rx_valid & (bus.rx_data == ACK_BYTE);
  assign rx_nack     = (state == WAIT_ACK) & ~img_mounted & ~rx_ack &
                       ((bus.rx_valid & (bus.rx_data == NACK_BYTE)) | (timer == TIMER_LAST));
  assign last_sector = (SECT_W'(n) + SECT_W'(1)) == sectors;
  assign pad         = {n, ptr} >= size_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = ERROR;
    end else begin
      case (state)
        IDLE, DONE, ERROR: if (start) state_d = img_ok ? SD_REQ : ERROR;
        SD_REQ:   if (bus.sd_ack) state_d = SD_XFER;
        SD_XFER:  if (!bus.sd_ack) state_d = TX_HDR;
        TX_HDR:   if (fire && pos == POS_HDR_LAST) state_d = TX_DATA;
        TX_DATA:  if (fire && pos == POS_DATA_LAST) state_d = TX_SUM;
        TX_SUM:   if (fire) state_d = WAIT_ACK;
        WAIT_ACK: begin
          if (rx_ack)       state_d = last_sector ? DONE : SD_REQ;
          else if (rx_nack) state_d = (retry == RETRY_MAX) ? ERROR : TX_HDR;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_start = (state_d == TX_HDR) && (state == SD_XFER || state == WAIT_ACK);
    load_data   = fire && (pos != '0) && (pos <= POS_W'(512));
    ptr_d       = ptr;
    if (frame_start)    ptr_d = '0;
    else if (load_data) ptr_d = ptr + 9'd1;
    busy_d  = state_d inside {SD_REQ, SD_XFER, TX_HDR, TX_DATA, TX_SUM, WAIT_ACK};
    done_d  = (state_d == DONE);
    error_d = error;
    if (start_go)                             error_d = img_ok ? 2'd0 : 2'd1;
    else if (abort)                           error_d = 2'd3;
    else if (rx_nack && retry == RETRY_MAX)   error_d = 2'd2;
  end

  // Sector buffer; read address runs one byte ahead so ready back-to-back has no bubble
  always_ff @(posedge clk_sys) begin
    if (state == SD_XFER && bus.sd_buff_wr) mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
    rd_data <= mem[ptr_d];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      img_ok     <= 1'b0;
      size_q     <= '0;
      sectors    <= '0;
      n          <= '0;
      retry      <= '0;
      timer      <= '0;
      pos        <= '0;
      ptr        <= '0;
      csum       <= '0;
      sd_lba_q   <= '0;
      sd_rd_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= '0;
      progress   <= '0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
      sd_rd_q <= (state_d == SD_REQ);
      ptr     <= ptr_d;
      timer   <= (state == WAIT_ACK) ? timer + 24'd1 : '0;

      if (img_mounted) begin
        img_ok  <= (img_size != 64'd0) && (img_size <= MAX_SIZE);
        size_q  <= img_size[SIZE_W-1:0];
        sectors <= SECT_W'(img_size[25:9]) + SECT_W'(|img_size[8:0]);
      end

      if (start_go) begin
        n        <= '0;
        retry    <= '0;
        progress <= '0;
        sd_lba_q <= '0;
      end

      if (rx_ack) begin
        progress <= n + 16'd1;
        retry    <= '0;
        if (!last_sector) begin
          n        <= n + 16'd1;
          sd_lba_q <= 32'(n + 16'd1);
        end
      end else if (rx_nack && retry != RETRY_MAX) begin
        retry <= retry + RETRY_W'(1);
      end

      // Frame byte sequencer: pos is the frame offset of the byte currently in tx_data
      if (frame_start) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= n[15:8];
        pos        <= '0;
        csum       <= '0;
      end else if (fire) begin
        csum <= csum ^ tx_data_q;
        pos  <= pos + POS_W'(1);
        if (pos == POS_SUM)            tx_valid_q <= 1'b0;
        else if (pos == '0)            tx_data_q  <= n[7:0];
        else if (pos == POS_DATA_LAST) tx_data_q  <= csum ^ tx_data_q;
        else                           tx_data_q  <= pad ? 8'hFF : rd_data;
      end
      if (abort) tx_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fw_sector_streamer.sv
// Scoreboard bench for fw_sector_streamer: HPS and UART peer models, byte monitor, directed tests.
module tb_fw_sector_streamer;
  localparam int unsigned FRAME_LEN = 515;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        busy, done;
  logic [1:0]  error;
  logic [15:0] progress;

  fw_sector_streamer_if bus();

  fw_sector_streamer #(
    .TIMEOUT_CYCLES(24'd100),
    .MAX_RETRY     (3),
    .ACK_BYTE      (8'h79),
    .NACK_BYTE     (8'h1F)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .start      (start),
    .img_mounted(img_mounted),
    .img_size   (img_size),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .progress   (progress)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] lba_q[$];
  logic [15:0] reply_q[$];
  int byte_cnt = 0, frames_done = 0, frames_replied = 0, sd_rd_cnt = 0;
  bit rand_ready = 1'b0;
  logic hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks tx_data holds while stalled
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && bus.tx_valid) check("tx_hold", 64'(bus.tx_data), 64'(data_prev));
      hold_prev = bus.tx_valid && !bus.tx_ready;
      data_prev = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got byte %0h expected no byte", bus.tx_data);
        end else begin
          check($sformatf("tx_byte%0d", byte_cnt), 64'(bus.tx_data), 64'(exp_q.pop_front()));
        end
        byte_cnt++;
        if (byte_cnt % FRAME_LEN == 0) frames_done++;
      end
    end
  end

  // UART TX back-pressure
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk_sys);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // STM32 model: per completed frame, optional leading byte then optional reply byte
  initial begin
    logic [15:0] r;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (frames_done > frames_replied) begin
        frames_replied++;
        if (reply_q.size() != 0) begin
          r = reply_q.pop_front();
          repeat (2) @(posedge clk_sys);
          if (r[15:8] != 8'h00) send_rx(r[15:8]);
          if (r[7:0] != 8'h00)  send_rx(r[7:0]);
        end
      end
    end
  end

  // HPS model: answers sd_rd with ack then 512 bytes of addr[7:0]
  initial begin
    bus.sd_ack       = 1'b0;
    bus.sd_buff_wr   = 1'b0;
    bus.sd_buff_addr = 9'd0;
    bus.sd_buff_dout = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (reset_n && bus.sd_rd) begin
        sd_rd_cnt++;
        if (lba_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sd_rd_extra: got lba %0d expected no request", bus.sd_lba);
        end else begin
          check("sd_lba", 64'(bus.sd_lba), 64'(lba_q.pop_front()));
        end
        @(posedge clk_sys);
        #1 bus.sd_ack = 1'b1;
        for (int a = 0; a < 512; a++) begin
          @(posedge clk_sys);
          #1;
          bus.sd_buff_wr   = 1'b1;
          bus.sd_buff_addr = 9'(a);
          bus.sd_buff_dout = 8'(a);
        end
        @(posedge clk_sys);
        #1;
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b0;
      end
    end
  end

  task automatic push_frame(input int n, input int size);
    logic [7:0] b, cs;
    b = 8'(n >> 8);
    exp_q.push_back(b);
    cs = b;
    b = 8'(n);
    exp_q.push_back(b);
    cs ^= b;
    for (int i = 0; i < 512; i++) begin
      b = (n * 512 + i >= size) ? 8'hFF : 8'(i);
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic mount(input logic [63:0] size);
    img_size    = size;
    img_mounted = 1'b1;
    tick(1);
    img_mounted = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
    end
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int k = 0;
    while (byte_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    if (byte_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, byte_cnt, target);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"},  64'(busy), 64'd0);
    check({name, "_done"},  64'(done), 64'd0);
    check({name, "_error"}, 64'(error), 64'd0);
    check({name, "_prog"},  64'(progress), 64'd0);
    check({name, "_sdrd"},  64'(bus.sd_rd), 64'd0);
    check({name, "_txv"},   64'(bus.tx_valid), 64'd0);
    check({name, "_lba"},   64'(bus.sd_lba), 64'd0);
  endtask

  task automatic new_test();
    reset_n = 1'b0;
    exp_q.delete();
    lba_q.delete();
    reply_q.delete();
    byte_cnt       = 0;
    frames_done    = 0;
    frames_replied = 0;
    sd_rd_cnt      = 0;
    rand_ready     = 1'b0;
    tick(2);
    check_reset_values("rst");
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    img_mounted = 1'b0;
    img_size    = 64'd0;

    // Two full sectors, junk byte before second ACK, start while busy ignored
    new_test();
    mount(64'd1024);
    push_frame(0, 1024);
    push_frame(1, 1024);
    lba_q.push_back(32'd0);
    lba_q.push_back(32'd1);
    reply_q.push_back(16'h0079);
    reply_q.push_back(16'h5579);
    pulse_start();
    tick(600);
    pulse_start();
    wait_idle(5000, "t1");
    check("t1_done", 64'(done), 64'd1);
    check("t1_prog", 64'(progress), 64'd2);
    check("t1_err", 64'(error), 64'd0);
    check("t1_left", 64'(exp_q.size()), 64'd0);
    check("t1_sdrd", 64'(sd_rd_cnt), 64'd2);

    // Partial last sector padded with FF, random back-pressure
    new_test();
    rand_ready = 1'b1;
    mount(64'd700);
    push_frame(0, 700);
    push_frame(1, 700);
    lba_q.push_back(32'd0);
    lba_q.push_back(32'd1);
    reply_q.push_back(16'h0079);
    reply_q.push_back(16'h0079);
    pulse_start();
    wait_idle(10000, "t2");
    check("t2_done", 64'(done), 64'd1);
    check("t2_prog", 64'(progress), 64'd2);
    check("t2_left", 64'(exp_q.size()), 64'd0);

    // NACK twice then ACK: resend from buffer without a second SD read
    new_test();
    mount(64'd512);
    repeat (3) push_frame(0, 512);
    lba_q.push_back(32'd0);
    reply_q.push_back(16'h001F);
    reply_q.push_back(16'h001F);
    reply_q.push_back(16'h0079);
    pulse_start();
    wait_idle(10000, "t3");
    check("t3_done", 64'(done), 64'd1);
    check("t3_prog", 64'(progress), 64'd1);
    check("t3_sdrd", 64'(sd_rd_cnt), 64'd1);
    check("t3_left", 64'(exp_q.size()), 64'd0);

    // Silence: four timed-out attempts then retries exhausted
    new_test();
    mount(64'd512);
    repeat (4) push_frame(0, 512);
    lba_q.push_back(32'd0);
    pulse_start();
    wait_idle(10000, "t4");
    check("t4_err", 64'(error), 64'd2);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    check("t4_bytes", 64'(byte_cnt), 64'(4 * FRAME_LEN));
    check("t4_left", 64'(exp_q.size()), 64'd0);

    // No image, zero size, and one byte over the size limit
    new_test();
    pulse_start();
    check("t5_noimg_err", 64'(error), 64'd1);
    check("t5_noimg_busy", 64'(busy), 64'd0);
    mount(64'd0);
    pulse_start();
    check("t5_zero_err", 64'(error), 64'd1);
    mount(64'h01FF_FE01);
    pulse_start();
    check("t5_big_err", 64'(error), 64'd1);
    tick(5);
    check("t5_sdrd", 64'(sd_rd_cnt), 64'd0);

    // Image change mid-TX_DATA aborts with code 3
    new_test();
    rand_ready = 1'b1;
    mount(64'd1024);
    push_frame(0, 1024);
    lba_q.push_back(32'd0);
    pulse_start();
    wait_bytes(100, 5000, "t6");
    mount(64'd1024);
    check("t6_txv", 64'(bus.tx_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_err", 64'(error), 64'd3);
    check("t6_done", 64'(done), 64'd0);

    // Reset mid-transfer clears outputs and the mounted flag
    new_test();
    mount(64'd1024);
    push_frame(0, 1024);
    lba_q.push_back(32'd0);
    pulse_start();
    wait_bytes(50, 5000, "t7");
    reset_n = 1'b0;
    tick(1);
    check_reset_values("t7_mid");
    exp_q.delete();
    reset_n = 1'b1;
    tick(1);
    pulse_start();
    check("t7_unmounted_err", 64'(error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
